// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered status flags,
// an occupancy count and one-cycle overflow/underflow error pulses.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_acc = wr_en & (~full_q | rd_en);
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    data_out_d     = data_out_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      data_out_d = mem[rd_ptr_q];
    end
    count_d        = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AFULL_C);
    almost_empty_d = (count_d <= AEMPTY_C);
    overflow_d     = wr_en & full_q & ~rd_en;
    underflow_d    = rd_en & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed check of sync_fifo against a queue-based model
// of occupancy, ordering and error-pulse rules.
module tb_sync_fifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = DEPTH - 1;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic          overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;
  logic          model_ovf  = 1'b0;
  logic          model_unf  = 1'b0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AFULL));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEMPTY));
    check({tag, ".data_out"},     32'(data_out),     32'(model_dout));
    check({tag, ".overflow"},     32'(overflow),     32'(model_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(model_unf));
  endtask

  // One clock of traffic; the model applies the FIFO rules to its pre-edge state.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [DW-1:0] din);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = wr; rd_en = rd; data_in = din;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    model_ovf = wr & was_full & ~rd;
    model_unf = rd & was_empty;
    if (rd && !was_empty) model_dout = model_q.pop_front();
    if (wr && (!was_full || rd)) model_q.push_back(din);
    #1;
    $display("step %-10s wr=%0b rd=%0b din=%02h -> count=%0d dout=%02h ovf=%0b unf=%0b",
             tag, wr, rd, din, count, data_out, overflow, underflow);
    check_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 8'h00);

    // Fill, then one rejected write.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 8'(i));
    step("overflow", 1'b1, 1'b0, 8'hFF);
    step("ovf_clear", 1'b0, 1'b0, 8'h00);

    // Drain in order, then one rejected read.
    for (int i = 1; i <= 8; i++) step("drain", 1'b0, 1'b1, 8'h00);
    check("drain_last", 32'(data_out), 32'h08);
    step("underflow", 1'b0, 1'b1, 8'h00);
    check("unf_hold", 32'(data_out), 32'h08);

    // Wrap-around through index 7 -> 0.
    for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) step("wrap_r6", 1'b0, 1'b1, 8'h00);
    check("wrap_last", 32'(data_out), 32'hA5);

    // Simultaneous read/write at count 3, at full, and at empty.
    for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, 8'(8'h30 + i));
    step("rw_at3", 1'b1, 1'b1, 8'h77);
    check("rw_at3_cnt", 32'(count), 32'd3);
    for (int i = 0; i < 5; i++) step("to_full", 1'b1, 1'b0, 8'(8'h40 + i));
    step("rw_full", 1'b1, 1'b1, 8'h88);
    check("rw_full_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step("empty_it", 1'b0, 1'b1, 8'h00);
    step("rw_empty", 1'b1, 1'b1, 8'h5A);
    check("rw_empty_unf", 32'(underflow), 32'd1);
    step("rd_5a", 1'b0, 1'b1, 8'h00);
    check("rd_5a_val", 32'(data_out), 32'h5A);

    // Asynchronous reset between edges with four entries held.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i));
    step("rd_pre_rst", 1'b0, 1'b1, 8'h00);
    step("pre_rst", 1'b1, 1'b0, 8'hC4);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    model_dout = '0; model_ovf = 1'b0; model_unf = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("post_w", 1'b1, 1'b0, 8'h33);
    step("post_r", 1'b0, 1'b1, 8'h00);
    check("post_val", 32'(data_out), 32'h33);

    // Random traffic: write-heavy then read-heavy phases reach both boundaries.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step("rand", 1'($urandom_range(99) < wp), 1'($urandom_range(99) < (100 - wp)),
           8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
